// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store, request accepted in IDLE,
// access performed LATENCY edges later, response held until the initiator takes it.
module data_mem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [63:0]   LIMIT    = 64'(DEPTH) * 64'd8;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [63:0] memory [DEPTH];

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          access, acc_err, mem_we;
  logic [AW-1:0] idx;

  always_comb begin
    idx     = addr_q[3 +: AW];
    // Full 64-bit unsigned compare so high addresses never alias into the array.
    acc_err = (addr_q[2:0] != 3'd0) || (addr_q >= LIMIT);
    access  = (state_q == WAIT) && (cnt_q == '0);
    mem_we  = access && wr_q && !acc_err;

    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = RESP;
          err_d   = acc_err;
          rdata_d = (wr_q || acc_err) ? 64'd0 : memory[idx];
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 64'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset; a store only lands on its access edge.
  always_ff @(posedge clk) begin
    if (mem_we) memory[idx] <= wdata_q;
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: round trip, latency, backpressure, errors, resets.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [63:0] req_addr, req_wdata, rsp_rdata;
  logic        r1_valid, r1_ready, r1_write, r1_rvalid, r1_rready, r1_err;
  logic [63:0] r1_addr, r1_wdata, r1_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(128), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH(128), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(r1_valid), .req_ready(r1_ready), .req_write(r1_write),
    .req_addr(r1_addr), .req_wdata(r1_wdata),
    .rsp_valid(r1_rvalid), .rsp_ready(r1_rready), .rsp_rdata(r1_rdata), .rsp_err(r1_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request and return 1ns after the accepting edge; inputs are then scrambled.
  task automatic start(input logic w, input logic [63:0] a, input logic [63:0] d);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(n < 50), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = ~w; req_addr = 64'h8; req_wdata = '1;
  endtask

  // Count edges after acceptance until rsp_valid is seen (sampled at negedge).
  task automatic wait_rsp(input int lat);
    int k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 64'(k), 64'(lat));
  endtask

  task automatic txn(input logic w, input logic [63:0] a, input logic [63:0] d, input int hold,
                     output logic [63:0] rd, output logic er);
    logic stable;
    start(w, a, d);
    wait_rsp(2);
    rd = rsp_rdata;
    er = rsp_err;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== rd || rsp_err !== er || req_ready) stable = 1'b0;
    end
    if (hold > 0) chk("hold_stable", 64'(stable), 64'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("post_hs_valid", 64'(rsp_valid), 64'd0);
    chk("post_hs_ready", 64'(req_ready), 64'd1);
    chk("post_hs_rdata", rsp_rdata, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    int last2, last1, bad2, bad1, n2, n1;

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    r1_valid = 1'b0; r1_write = 1'b0; r1_addr = 64'h10; r1_wdata = '0; r1_rready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    reset = 1'b0;

    dut.memory[1]   = 64'h77;
    dut.memory[2]   = 64'h0;
    dut.memory[5]   = 64'h1234;
    dut.memory[127] = 64'hA5A5_0000_1111_2222;

    // Store/load round trip
    txn(1'b1, 64'h10, 64'hDEADBEEFCAFEF00D, 0, rd, er);
    chk("st_rdata", rd, 64'd0);
    chk("st_err", 64'(er), 64'd0);
    chk("st_mem2", dut.memory[2], 64'hDEADBEEFCAFEF00D);
    txn(1'b0, 64'h10, 64'h0, 0, rd, er);
    chk("ld_rdata", rd, 64'hDEADBEEFCAFEF00D);
    chk("ld_err", 64'(er), 64'd0);

    // Backpressure: response held 10 cycles
    txn(1'b0, 64'h28, 64'h0, 10, rd, er);
    chk("bp_rdata", rd, 64'h1234);
    chk("bp_err", 64'(er), 64'd0);

    // Error cases
    txn(1'b1, 64'h14, 64'hBAD, 0, rd, er);
    chk("mis_err", 64'(er), 64'd1);
    chk("mis_rdata", rd, 64'd0);
    chk("mis_mem2", dut.memory[2], 64'hDEADBEEFCAFEF00D);
    txn(1'b0, 64'h400, 64'h0, 0, rd, er);
    chk("oor_err", 64'(er), 64'd1);
    chk("oor_rdata", rd, 64'd0);
    txn(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 0, rd, er);
    chk("hi_err", 64'(er), 64'd1);
    txn(1'b0, 64'h3F8, 64'h0, 0, rd, er);
    chk("top_err", 64'(er), 64'd0);
    chk("top_rdata", rd, 64'hA5A5_0000_1111_2222);

    // Throughput with rsp_ready high: L=2 every 4 cycles, L=1 every 3 cycles
    rsp_ready = 1'b1;
    last2 = -1; last1 = -1; bad2 = 0; bad1 = 0; n2 = 0; n1 = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10;
    r1_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        if (last2 >= 0 && i - last2 != 4) bad2++;
        last2 = i; n2++;
      end
      if (r1_ready) begin
        if (last1 >= 0 && i - last1 != 3) bad1++;
        last1 = i; n1++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0; r1_valid = 1'b0;
    chk("thr2_gap", 64'(bad2), 64'd0);
    chk("thr2_count", 64'(n2), 64'd5);
    chk("thr1_gap", 64'(bad1), 64'd0);
    chk("thr1_count", 64'(n1), 64'd7);
    repeat (6) @(negedge clk);
    rsp_ready = 1'b0;
    chk("thr_idle", 64'(req_ready), 64'd1);

    // Reset while a store is waiting: store is dropped
    start(1'b1, 64'h08, 64'h55);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rw_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rw_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rw_mem1", dut.memory[1], 64'h77);

    // Reset while a response is pending
    start(1'b0, 64'h10, 64'h0);
    wait_rsp(2);
    chk("rr_pre_rdata", rsp_rdata, 64'hDEADBEEFCAFEF00D);
    #2 reset = 1'b1;
    #1;
    chk("rr_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rr_rsp_rdata", rsp_rdata, 64'd0);
    chk("rr_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    chk("rr_mem2", dut.memory[2], 64'hDEADBEEFCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
